ling_sub32_pipe: RTL and testbench

Four-stage pipelined 32-bit subtractor, diff = a − b, built from the team's 4-bit Ling carry blocks. Operates as a + ~b + 1: the Ling chain's carry-in is forced to 1 and b is inverted. The carry chain is cut into 8-bit slices with registered carries, so the block closes timing where the combinational 32-bit Ling adder cannot. It sits between the operand source and the result consumer with valid/ready handshakes on both sides.

---
 rtl/ling_sub32_pipe.sv | 150 +++++++++++++++
 tb/tb_ling_sub32_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ling_sub32_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ling_sub32_pipe
//  Purpose  : Four-stage pipelined 32-bit subtractor (diff = a - b) computed
//             as a + ~b + 1 on 8-bit slices of chained 4-bit Ling carry
//             blocks, with registered carries between slices and
//             valid/ready handshakes on both sides.
//  Options  : LING_SUB_OVF_EN - when defined, ovf reports signed overflow of
//             a - b; otherwise ovf is tied to 0 and costs no registers.
//  Revision : 1.0 - initial release
// ============================================================================
module ling_sub32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        ovf
);

    // Subtraction as a + ~b + 1: the chain's first carry-in is always set.
    localparam logic c_CIN = 1'b1;

    // 4-bit Ling block: pseudo-carries h expanded flat, real carry c(i+1) = t(i) & h(i+1).
    function automatic logic [4:0] ling4(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
        logic [3:0] g, t, p;
        logic       h1, h2, h3, h4;
        g  = x & y;
        t  = x | y;
        p  = x ^ y;
        h1 = g[0] | ci;
        h2 = g[1] | (t[0] & g[0]) | (t[0] & ci);
        h3 = g[2] | (t[1] & g[1]) | (t[1] & t[0] & g[0]) | (t[1] & t[0] & ci);
        h4 = g[3] | (t[2] & g[2]) | (t[2] & t[1] & g[1]) | (t[2] & t[1] & t[0] & g[0])
                  | (t[2] & t[1] & t[0] & ci);
        return {t[3] & h4,
                p[3] ^ (t[2] & h3),
                p[2] ^ (t[1] & h2),
                p[1] ^ (t[0] & h1),
                p[0] ^ ci};
    endfunction

    // 8-bit slice: lower nibble carry-out feeds the upper nibble block.
    function automatic logic [8:0] ling8(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
        logic [4:0] lo, hi;
        lo = ling4(x[3:0], y[3:0], ci);
        hi = ling4(x[7:4], y[7:4], lo[4]);
        return {hi, lo[3:0]};
    endfunction

    // Stage tokens: operand bits still to be consumed, finished diff bits, carry.
    logic        r0_vld, r1_vld, r2_vld, r3_vld, r_out_vld;
    logic [31:0] r0_a, r0_b;
    logic [31:8] r1_a, r1_b;
    logic [31:16] r2_a, r2_b;
    logic [31:24] r3_a, r3_b;
    logic [7:0]  r1_d;
    logic [15:0] r2_d;
    logic [23:0] r3_d;
    logic        r1_c, r2_c, r3_c;
    logic [31:0] r_diff;
    logic        r_borrow;

    logic [8:0]  w_s0, w_s1, w_s2, w_s3;
    logic        w_adv;

    assign w_s0 = ling8(r0_a[7:0],   ~r0_b[7:0],   c_CIN);
    assign w_s1 = ling8(r1_a[15:8],  ~r1_b[15:8],  r1_c);
    assign w_s2 = ling8(r2_a[23:16], ~r2_b[23:16], r2_c);
    assign w_s3 = ling8(r3_a[31:24], ~r3_b[31:24], r3_c);

    // Outputs are masked while rst is high so they read as idle immediately.
    assign out_valid = r_out_vld & ~rst;
    assign diff      = rst ? 32'd0 : r_diff;
    assign borrow    = r_borrow & ~rst;
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;

    // Valid bits: cleared by reset, shifted forward on every advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_vld    <= 1'b0;
            r1_vld    <= 1'b0;
            r2_vld    <= 1'b0;
            r3_vld    <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (w_adv) begin
            r0_vld    <= in_valid;
            r1_vld    <= r0_vld;
            r2_vld    <= r1_vld;
            r3_vld    <= r2_vld;
            r_out_vld <= r3_vld;
        end
    end

    // Token data: no reset needed, bubble contents are never presented.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r0_a <= a;
            r0_b <= b;
            r1_a <= r0_a[31:8];
            r1_b <= r0_b[31:8];
            r1_d <= w_s0[7:0];
            r1_c <= w_s0[8];
            r2_a <= r1_a[31:16];
            r2_b <= r1_b[31:16];
            r2_d <= {w_s1[7:0], r1_d};
            r2_c <= w_s1[8];
            r3_a <= r2_a[31:24];
            r3_b <= r2_b[31:24];
            r3_d <= {w_s2[7:0], r2_d};
            r3_c <= w_s2[8];
        end
    end

    // Result register: only real tokens update it, so it holds 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= 32'd0;
            r_borrow <= 1'b0;
        end else if (w_adv && r3_vld) begin
            r_diff   <= {w_s3[7:0], r3_d};
            r_borrow <= ~w_s3[8];
        end
    end

`ifdef LING_SUB_OVF_EN
    // Signed overflow: operand signs differ and the result sign departs from a.
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv && r3_vld) begin
            r_ovf <= (r3_a[31] != r3_b[31]) && (w_s3[7] != r3_a[31]);
        end
    end
    assign ovf = r_ovf & ~rst;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ling_sub32_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ling_sub32_pipe
//  Purpose  : Self-checking bench for ling_sub32_pipe: directed vector table,
//             backpressured stream against a golden model, mid-flight reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ling_sub32_pipe;

`ifdef LING_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, borrow, ovf;
    logic [31:0] a, b, diff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        br;
        logic        ov;
    } vec_t;

    vec_t        tv[NV];
    logic [31:0] pa[8], pb[8];
    logic [33:0] expq[$];
    logic [33:0] front;
    logic [31:0] held;
    int          sent, rcvd;

    ling_sub32_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        tv[0]  = '{32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0};
        tv[1]  = '{32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0};
        tv[2]  = '{32'd0,        32'd0,        32'h00000000, 1'b0, 1'b0};
        tv[3]  = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        tv[4]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
        tv[5]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
        tv[6]  = '{32'h01000000, 32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0};
        tv[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
        tv[8]  = '{32'h12345678, 32'h00000001, 32'h12345677, 1'b0, 1'b0};
        tv[9]  = '{32'h0000FFFF, 32'h00010000, 32'hFFFFFFFF, 1'b1, 1'b0};
        tv[10] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        tv[11] = '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_diff",      diff,               32'd0);
        chk("rst_borrow",    {31'd0, borrow},    32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        rst = 1'b0;

        // Directed table, back-to-back; vector j must appear exactly at step j+5
        for (int j = 0; j < NV + 6; j++) begin
            @(negedge clk);
            if (j >= 5 && j - 5 < NV) begin
                chk($sformatf("tv%0d_valid", j - 5), {31'd0, out_valid}, 32'd1);
                chk($sformatf("tv%0d_diff", j - 5), diff, tv[j-5].d);
                chk($sformatf("tv%0d_borrow", j - 5), {31'd0, borrow}, {31'd0, tv[j-5].br});
                chk($sformatf("tv%0d_ovf", j - 5), {31'd0, ovf}, {31'd0, tv[j-5].ov & OVF_ON});
            end else begin
                chk($sformatf("tv_idle%0d_valid", j), {31'd0, out_valid}, 32'd0);
            end
            if (j < NV) begin
                in_valid = 1'b1; a = tv[j].a; b = tv[j].b;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Streaming with a 3-cycle out_ready drop while the pipe is full
        for (int i = 0; i < 8; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        sent = 0; rcvd = 0; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 7 && cyc <= 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a = pa[sent]; b = pb[sent];
            end
            #1;
            if (cyc >= 7 && cyc <= 9) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
                chk($sformatf("bp_stall_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
                if (cyc == 7) held = diff;
                else chk($sformatf("bp_hold_c%0d", cyc), diff, held);
            end else begin
                chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("bp_spurious_result", 32'd1, 32'd0);
                end else begin
                    front = expq.pop_front();
                    chk($sformatf("bp_r%0d_diff", rcvd), diff, front[31:0]);
                    chk($sformatf("bp_r%0d_flags", rcvd), {30'd0, ovf, borrow},
                        {30'd0, front[33:32]});
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back({OVF_ON && (a[31] != b[31]) && ((a - b) >> 31 != {31'd0, a[31]}),
                                a < b, a - b});
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_received", rcvd, 32'd8);

        // Reset mid-flight: three tokens in flight must vanish
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'd100 + k; b = 32'd1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_valid_during", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_diff_during",  diff,               32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid_after", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_diff_after",  diff,               32'd0);
        in_valid = 1'b1; a = 32'd10; b = 32'd4;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("post_rst_valid_s%0d", j), {31'd0, out_valid}, {31'd0, j == 5});
            if (j == 5) begin
                chk("post_rst_diff",   diff,              32'd6);
                chk("post_rst_borrow", {31'd0, borrow},   32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
